keypad_scanner: RTL and testbench

Input-side counterpart of the LED matrix driver: scans a passive row/column key matrix by strobing one row at a time and sampling the column returns. Scan results are synchronized and debounced across whole scans, and each accepted key press becomes a single-cycle event carrying the key code. Sits beside the button debouncers, on the divided game clock, and feeds column selections to the game logic.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/keypad_sync_2ff.sv | 23 ++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the key matrix scanner: FSM states, scan classification
// and the per-scan result record that feeds the debouncer.
package keypad_pkg;

  typedef enum logic {S_DRIVE, S_EVAL} scan_state_t;

  typedef enum logic [1:0] {K_NONE, K_SINGLE, K_MULTI} scan_kind_t;

  // Wide enough for any matrix up to 256 keys; the top slices what it needs.
  localparam int CODE_MAX_W = 8;

  typedef struct packed {
    scan_kind_t            kind;
    logic [CODE_MAX_W-1:0] code;
  } scan_res_t;

endpackage

// File: rtl/keypad_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobed key matrix scanner: builds a scan image, classifies it once per
// scan, debounces across whole scans and emits single-cycle key events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [COLS-1:0]               col_in,
  output logic [ROWS-1:0]               row_drive,
  output logic                          key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_held,
  output logic                          scan_tick
);

  localparam int NKEYS  = ROWS * COLS;
  localparam int CODE_W = $clog2(NKEYS);
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW     = $clog2(SETTLE);
  localparam int CW     = $clog2(DEBOUNCE + 1);

  scan_state_t state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [SW-1:0] s_q, s_d;
  logic          sample;

  logic [COLS-1:0]  col_sync;
  logic [NKEYS-1:0] img_q;

  scan_res_t       res, cand_q;
  logic [1:0]      npress;
  logic [CODE_MAX_W-1:0] last;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            same, sat, reached;

  sync_2ff #(.WIDTH(COLS)) u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (col_in),
    .q     (col_sync)
  );

  // ---------------- scan FSM ----------------
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_DRIVE;
      r_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    s_d       = s_q;
    sample    = 1'b0;
    scan_tick = 1'b0;
    row_drive = '1;
    case (state_q)
      S_DRIVE: begin
        row_drive = ~(ROWS'(1) << r_q);
        if (s_q == SW'(SETTLE - 1)) begin
          sample = 1'b1;
          s_d    = '0;
          if (r_q == RW'(ROWS - 1)) state_d = S_EVAL;
          else                      r_d     = r_q + RW'(1);
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      S_EVAL: begin
        scan_tick = 1'b1;
        r_d       = '0;
        s_d       = '0;
        state_d   = S_DRIVE;
      end
      default: state_d = S_DRIVE;
    endcase
    // Rows float high and no tick escapes while reset is held.
    if (rst) begin
      row_drive = '1;
      scan_tick = 1'b0;
    end
  end

  // Scan image holds one bit per key, set = pressed.
  always_ff @(posedge clock) begin
    if (rst)         img_q <= '0;
    else if (sample) img_q[int'(r_q)*COLS +: COLS] <= ~col_sync;
  end

  // ---------------- classification ----------------
  always_comb begin
    npress = '0;
    last   = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (img_q[i]) begin
        if (npress != 2'd2) npress = npress + 2'd1;
        last = CODE_MAX_W'(i);
      end
    end
    res.kind = K_NONE;
    res.code = '0;
    case (npress)
      2'd0:    res.kind = K_NONE;
      2'd1: begin
        res.kind = K_SINGLE;
        res.code = last;
      end
      default: res.kind = K_MULTI;
    endcase
  end

  // ---------------- debounce ----------------
  always_comb begin
    same    = (res == cand_q);
    sat     = (cnt_q == CW'(DEBOUNCE));
    cnt_d   = !same ? CW'(1) : (sat ? cnt_q : cnt_q + CW'(1));
    // Acceptance only on the scan that first hits the threshold.
    reached = (cnt_d == CW'(DEBOUNCE)) && !(same && sat);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cand_q    <= '{kind: K_NONE, code: '0};
      cnt_q     <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (state_q == S_EVAL) begin
        cand_q <= res;
        cnt_q  <= cnt_d;
        if (reached) begin
          case (res.kind)
            K_SINGLE: begin
              if (!key_held || key_code != res.code[CODE_W-1:0]) begin
                key_valid <= 1'b1;
                key_code  <= res.code[CODE_W-1:0];
                key_held  <= 1'b1;
              end
            end
            K_NONE:  key_held <= 1'b0;
            default: ;  // chords and ghosting leave outputs untouched
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural passive key matrix.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_drive;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        scan_tick;
  logic [15:0] keys = '0;

  int nerr = 0;
  int nchk = 0;

  always #5 clock = ~clock;

  keypad_scanner dut (
    .clock     (clock),
    .rst       (rst),
    .col_in    (col_in),
    .row_drive (row_drive),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .scan_tick (scan_tick)
  );

  // Column c pulls low when its row is strobed and key (r,c) is closed.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_drive[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles, counting key_valid pulses and keeping the last pulsed code.
  task automatic watch(input int n, output int pulses, output logic [3:0] code);
    pulses = 0;
    code   = 4'hx;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (key_valid) begin
        pulses++;
        code = key_code;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"},   32'(row_drive), 32'hF);
    check({tag, "_valid"}, 32'(key_valid), 0);
    check({tag, "_code"},  32'(key_code),  0);
    check({tag, "_held"},  32'(key_held),  0);
    check({tag, "_tick"},  32'(scan_tick), 0);
  endtask

  initial begin
    int         p;
    int         total;
    logic [3:0] c;
    logic [3:0] exp_row;
    bit         found;

    // 1: reset and the bare scan pattern
    repeat (3) begin
      @(negedge clock);
      check_reset_outputs("rst");
    end
    @(posedge clock);
    #1 rst = 1'b0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clock);
      exp_row = (k % 17 == 16) ? 4'b1111 : ~(4'b0001 << ((k % 17) / 4));
      check("scan_row",   32'(row_drive), 32'(exp_row));
      check("scan_tick",  32'(scan_tick), (k % 17 == 16) ? 1 : 0);
      check("scan_valid", 32'(key_valid), 0);
      check("scan_code",  32'(key_code),  0);
    end

    // 2: clean press of (2,1)
    keys[9] = 1'b1;
    watch(70, p, c);
    check("press_pulses", 32'(p), 1);
    check("press_code",   32'(c), 9);
    check("press_held",   32'(key_held), 1);
    watch(51, p, c);
    check("press_nodup",  32'(p), 0);
    check("press_held2",  32'(key_held), 1);

    // 5: release of (2,1)
    keys[9] = 1'b0;
    watch(70, p, c);
    check("rel_pulses", 32'(p), 0);
    check("rel_held",   32'(key_held), 0);
    check("rel_code",   32'(key_code), 9);

    // 3: (0,3) flips once per scan so consecutive scans always disagree
    total = 0;
    for (int t = 0; t < 12; t++) begin
      keys[3] = ~keys[3];
      watch(17, p, c);
      total += p;
    end
    keys[3] = 1'b0;
    watch(51, p, c);
    total += p;
    check("bounce_pulses", 32'(total), 0);
    check("bounce_held",   32'(key_held), 0);

    // 4: two-key chord is ignored
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    watch(170, p, c);
    check("multi_pulses", 32'(p), 0);
    check("multi_code",   32'(key_code), 9);
    check("multi_held",   32'(key_held), 0);
    keys = '0;
    watch(51, p, c);
    check("multi_clear", 32'(p), 0);

    // 6: press (3,3), then reset mid-scan while row 2 is strobed
    keys[15] = 1'b1;
    watch(70, p, c);
    check("k15_pulses", 32'(p), 1);
    check("k15_code",   32'(c), 15);
    check("k15_held",   32'(key_held), 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (row_drive == 4'b1011) found = 1'b1;
    end
    check("row2_seen", 32'(found), 1);
    rst = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrst");
    @(posedge clock);
    #1 rst = 1'b0;
    watch(70, p, c);
    check("reacc_pulses", 32'(p), 1);
    check("reacc_code",   32'(c), 15);
    check("reacc_held",   32'(key_held), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
